// File: rtl/dmem_lane_credit_gate.sv
// dmem_lane_credit_gate: per-lane outstanding-request cap and registered response FIFO toward the data memory
module dmem_lane_credit_gate #(
  parameter int ARCH_LEN = 32,
  parameter int DMEM_DATA_BITS = 32,
  parameter int DMEM_TAG_BITS = 32,
  parameter int NUM_LANES = 1,
  parameter int DEPTH = 4,
  localparam int SZ = $clog2($clog2(DMEM_DATA_BITS/8)+1),
  localparam int MK = DMEM_DATA_BITS/8,
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_LANES-1:0]                core_req_valid,
  output logic [NUM_LANES-1:0]                core_req_ready,
  input  logic [NUM_LANES-1:0]                core_req_bits_store,
  input  logic [NUM_LANES*DMEM_TAG_BITS-1:0]  core_req_bits_tag,
  input  logic [NUM_LANES*ARCH_LEN-1:0]       core_req_bits_address,
  input  logic [NUM_LANES*SZ-1:0]             core_req_bits_size,
  input  logic [NUM_LANES*DMEM_DATA_BITS-1:0] core_req_bits_data,
  input  logic [NUM_LANES*MK-1:0]             core_req_bits_mask,
  output logic [NUM_LANES-1:0]                mem_req_valid,
  input  logic [NUM_LANES-1:0]                mem_req_ready,
  output logic [NUM_LANES-1:0]                mem_req_bits_store,
  output logic [NUM_LANES*DMEM_TAG_BITS-1:0]  mem_req_bits_tag,
  output logic [NUM_LANES*ARCH_LEN-1:0]       mem_req_bits_address,
  output logic [NUM_LANES*SZ-1:0]             mem_req_bits_size,
  output logic [NUM_LANES*DMEM_DATA_BITS-1:0] mem_req_bits_data,
  output logic [NUM_LANES*MK-1:0]             mem_req_bits_mask,
  input  logic [NUM_LANES-1:0]                mem_resp_valid,
  output logic [NUM_LANES-1:0]                mem_resp_ready,
  input  logic [NUM_LANES*DMEM_TAG_BITS-1:0]  mem_resp_bits_tag,
  input  logic [NUM_LANES*DMEM_DATA_BITS-1:0] mem_resp_bits_data,
  output logic [NUM_LANES-1:0]                core_resp_valid,
  input  logic [NUM_LANES-1:0]                core_resp_ready,
  output logic [NUM_LANES*DMEM_TAG_BITS-1:0]  core_resp_bits_tag,
  output logic [NUM_LANES*DMEM_DATA_BITS-1:0] core_resp_bits_data,
  output logic [NUM_LANES*CW-1:0]             credits_used,
  output logic [NUM_LANES-1:0]                err_orphan_resp
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = DMEM_TAG_BITS;
  localparam int DW = DMEM_DATA_BITS;

  assign mem_req_bits_store   = core_req_bits_store;
  assign mem_req_bits_tag     = core_req_bits_tag;
  assign mem_req_bits_address = core_req_bits_address;
  assign mem_req_bits_size    = core_req_bits_size;
  assign mem_req_bits_data    = core_req_bits_data;
  assign mem_req_bits_mask    = core_req_bits_mask;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [CW-1:0] inflight_q, inflight_d, occ_q, occ_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic          err_q, err_d;
    logic [TW-1:0] tag_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic          credit_ok, req_fire, resp_in, resp_legal, resp_out;
    // credit check uses registered state only, so a same-cycle pop never opens a slot
    assign credit_ok  = (inflight_q + occ_q) < CW'(DEPTH);
    assign req_fire   = core_req_valid[g] & credit_ok & mem_req_ready[g];
    assign resp_in    = mem_resp_valid[g] & (occ_q < CW'(DEPTH));
    assign resp_legal = resp_in & (inflight_q != '0);
    assign resp_out   = (occ_q != '0) & core_resp_ready[g];

    assign mem_req_valid[g]   = core_req_valid[g] & credit_ok;
    assign core_req_ready[g]  = mem_req_ready[g] & credit_ok;
    assign mem_resp_ready[g]  = occ_q < CW'(DEPTH);
    assign core_resp_valid[g] = occ_q != '0;
    assign core_resp_bits_tag[g*TW +: TW]  = tag_mem[head_q];
    assign core_resp_bits_data[g*DW +: DW] = data_mem[head_q];
    assign credits_used[g*CW +: CW] = inflight_q + occ_q;
    assign err_orphan_resp[g] = err_q;

    always_comb begin
      inflight_d = inflight_q + CW'(req_fire) - CW'(resp_legal);
      occ_d      = occ_q + CW'(resp_in) - CW'(resp_out);
      head_d     = head_q + PW'(resp_out);
      tail_d     = tail_q + PW'(resp_in);
      err_d      = err_q | (resp_in & ~resp_legal);
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        inflight_q <= '0;
        occ_q      <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        err_q      <= 1'b0;
      end else begin
        inflight_q <= inflight_d;
        occ_q      <= occ_d;
        head_q     <= head_d;
        tail_q     <= tail_d;
        err_q      <= err_d;
      end
    end

    always_ff @(posedge clock) begin
      if (resp_in) begin
        tag_mem[tail_q]  <= mem_resp_bits_tag[g*TW +: TW];
        data_mem[tail_q] <= mem_resp_bits_data[g*DW +: DW];
      end
    end

    // an orphan arriving alongside a fresh request can push past the cap; that case is already flagged
    assert property (@(posedge clock) disable iff (reset)
      err_q || ({1'b0, inflight_q} + {1'b0, occ_q}) <= (CW+1)'(DEPTH));
  end
endmodule

// File: tb/tb_dmem_lane_credit_gate.sv
// tb_dmem_lane_credit_gate: directed scenario bench for a two-lane credit gate
module tb_dmem_lane_credit_gate;
  localparam int L = 2, AW = 32, DW = 32, TW = 32, SZ = 2, MK = 4, CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [L-1:0]    core_req_valid = '0, core_req_ready, core_req_bits_store = '0;
  logic [L*TW-1:0] core_req_bits_tag = '0;
  logic [L*AW-1:0] core_req_bits_address = '0;
  logic [L*SZ-1:0] core_req_bits_size = '0;
  logic [L*DW-1:0] core_req_bits_data = '0;
  logic [L*MK-1:0] core_req_bits_mask = '0;
  logic [L-1:0]    mem_req_valid, mem_req_ready = '1, mem_req_bits_store;
  logic [L*TW-1:0] mem_req_bits_tag;
  logic [L*AW-1:0] mem_req_bits_address;
  logic [L*SZ-1:0] mem_req_bits_size;
  logic [L*DW-1:0] mem_req_bits_data;
  logic [L*MK-1:0] mem_req_bits_mask;
  logic [L-1:0]    mem_resp_valid = '0, mem_resp_ready;
  logic [L*TW-1:0] mem_resp_bits_tag = '0;
  logic [L*DW-1:0] mem_resp_bits_data = '0;
  logic [L-1:0]    core_resp_valid, core_resp_ready = '0;
  logic [L*TW-1:0] core_resp_bits_tag;
  logic [L*DW-1:0] core_resp_bits_data;
  logic [L*CW-1:0] credits_used;
  logic [L-1:0]    err_orphan_resp;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  dmem_lane_credit_gate #(.ARCH_LEN(AW), .DMEM_DATA_BITS(DW), .DMEM_TAG_BITS(TW),
                          .NUM_LANES(L), .DEPTH(4)) dut (
    .clock(clk), .reset(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_bits_store(core_req_bits_store), .core_req_bits_tag(core_req_bits_tag),
    .core_req_bits_address(core_req_bits_address), .core_req_bits_size(core_req_bits_size),
    .core_req_bits_data(core_req_bits_data), .core_req_bits_mask(core_req_bits_mask),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_bits_store(mem_req_bits_store), .mem_req_bits_tag(mem_req_bits_tag),
    .mem_req_bits_address(mem_req_bits_address), .mem_req_bits_size(mem_req_bits_size),
    .mem_req_bits_data(mem_req_bits_data), .mem_req_bits_mask(mem_req_bits_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_bits_tag(mem_resp_bits_tag), .mem_resp_bits_data(mem_resp_bits_data),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_bits_tag(core_resp_bits_tag), .core_resp_bits_data(core_resp_bits_data),
    .credits_used(credits_used), .err_orphan_resp(err_orphan_resp)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    core_req_valid = 2'b01;
    #1;
    n_cmp++; if (credits_used !== 6'd0) begin n_err++; $display("FAIL rst_credits got %h exp 0", credits_used); end
    n_cmp++; if (core_resp_valid !== 2'b00) begin n_err++; $display("FAIL rst_resp_valid got %b exp 00", core_resp_valid); end
    n_cmp++; if (mem_resp_ready !== 2'b11) begin n_err++; $display("FAIL rst_mem_resp_ready got %b exp 11", mem_resp_ready); end
    n_cmp++; if (err_orphan_resp !== 2'b00) begin n_err++; $display("FAIL rst_err got %b exp 00", err_orphan_resp); end
    n_cmp++; if (core_req_ready !== 2'b11) begin n_err++; $display("FAIL rst_req_ready got %b exp 11", core_req_ready); end
    n_cmp++; if (mem_req_valid !== 2'b01) begin n_err++; $display("FAIL rst_mem_req_valid got %b exp 01", mem_req_valid); end
    core_req_valid = 2'b00;
    #8 rst = 1'b0;
    step();
  endtask

  task automatic test_credit_cap;
    int fires = 0;
    core_req_valid = 2'b01;
    core_req_bits_address[31:0] = 32'h1000_0040;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_cmp++; if (core_req_ready[0] !== 1'(i <= 4)) begin n_err++; $display("FAIL cap_ready cyc %0d got %b exp %b", i, core_req_ready[0], i <= 4); end
      if (mem_req_valid[0] && mem_req_ready[0]) fires++;
      step();
    end
    core_req_valid = 2'b00;
    n_cmp++; if (fires != 4) begin n_err++; $display("FAIL cap_fires got %0d exp 4", fires); end
    @(negedge clk);
    n_cmp++; if (credits_used !== 6'o04) begin n_err++; $display("FAIL cap_credits got %o exp 04", credits_used); end
    n_cmp++; if (mem_req_bits_address[31:0] !== 32'h1000_0040) begin n_err++; $display("FAIL cap_addr_pass got %h exp 10000040", mem_req_bits_address[31:0]); end
    step();
  endtask

  task automatic test_resp_latency;
    core_resp_ready = 2'b01;
    mem_resp_valid = 2'b01;
    mem_resp_bits_tag[31:0] = 32'h11;
    mem_resp_bits_data[31:0] = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (core_resp_valid[0] !== 1'b0) begin n_err++; $display("FAIL lat_no_bypass got %b exp 0", core_resp_valid[0]); end
    n_cmp++; if (mem_resp_ready[0] !== 1'b1) begin n_err++; $display("FAIL lat_mem_ready got %b exp 1", mem_resp_ready[0]); end
    step();
    mem_resp_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (core_resp_valid[0] !== 1'b1) begin n_err++; $display("FAIL lat_valid got %b exp 1", core_resp_valid[0]); end
    n_cmp++; if (core_resp_bits_tag[31:0] !== 32'h11) begin n_err++; $display("FAIL lat_tag got %h exp 11", core_resp_bits_tag[31:0]); end
    n_cmp++; if (core_resp_bits_data[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lat_data got %h exp deadbeef", core_resp_bits_data[31:0]); end
    n_cmp++; if (credits_used !== 6'o04) begin n_err++; $display("FAIL lat_credits_t1 got %o exp 04", credits_used); end
    step();
    @(negedge clk);
    n_cmp++; if (credits_used !== 6'o03) begin n_err++; $display("FAIL lat_credits_t2 got %o exp 03", credits_used); end
    step();
    mem_resp_valid = 2'b01;
    repeat (3) step();
    mem_resp_valid = 2'b00;
    step();
    core_resp_ready = 2'b00;
    @(negedge clk);
    n_cmp++; if (credits_used !== 6'o00) begin n_err++; $display("FAIL lat_drain got %o exp 00", credits_used); end
    step();
  endtask

  task automatic test_fifo_full;
    core_req_valid = 2'b01;
    repeat (4) step();
    core_req_valid = 2'b00;
    mem_resp_valid = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      mem_resp_bits_tag[31:0] = k;
      step();
    end
    mem_resp_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (credits_used !== 6'o04) begin n_err++; $display("FAIL full_credits got %o exp 04", credits_used); end
    n_cmp++; if (mem_resp_ready[0] !== 1'b0) begin n_err++; $display("FAIL full_mem_ready got %b exp 0", mem_resp_ready[0]); end
    n_cmp++; if (core_req_ready[0] !== 1'b0) begin n_err++; $display("FAIL full_req_ready got %b exp 0", core_req_ready[0]); end
    step();
    core_resp_ready = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (core_resp_valid[0] !== 1'b1 || core_resp_bits_tag[31:0] !== 32'(k)) begin
        n_err++; $display("FAIL full_pop%0d got v=%b tag=%h exp v=1 tag=%h", k, core_resp_valid[0], core_resp_bits_tag[31:0], k);
      end
      step();
    end
    core_resp_ready = 2'b00;
    @(negedge clk);
    n_cmp++; if (core_resp_valid[0] !== 1'b0 || credits_used !== 6'o00) begin
      n_err++; $display("FAIL full_empty got v=%b credits=%o exp v=0 credits=00", core_resp_valid[0], credits_used);
    end
    step();
  endtask

  task automatic test_back_to_back;
    core_req_valid = 2'b01;
    repeat (2) step();
    core_req_valid = 2'b00;
    mem_resp_valid = 2'b01;
    mem_resp_bits_tag[31:0] = 32'h21;
    step();
    mem_resp_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (credits_used !== 6'o02) begin n_err++; $display("FAIL b2b_pre got %o exp 02", credits_used); end
    step();
    core_req_valid = 2'b01;
    mem_resp_valid = 2'b01;
    mem_resp_bits_tag[31:0] = 32'h22;
    core_resp_ready = 2'b01;
    @(negedge clk);
    n_cmp++; if (core_req_ready[0] !== 1'b1) begin n_err++; $display("FAIL b2b_req_ready got %b exp 1", core_req_ready[0]); end
    n_cmp++; if (core_resp_bits_tag[31:0] !== 32'h21) begin n_err++; $display("FAIL b2b_head got %h exp 21", core_resp_bits_tag[31:0]); end
    step();
    core_req_valid = 2'b00;
    mem_resp_valid = 2'b00;
    core_resp_ready = 2'b00;
    @(negedge clk);
    n_cmp++; if (credits_used !== 6'o02) begin n_err++; $display("FAIL b2b_used got %o exp 02", credits_used); end
    n_cmp++; if (core_resp_valid[0] !== 1'b1 || core_resp_bits_tag[31:0] !== 32'h22) begin
      n_err++; $display("FAIL b2b_next got v=%b tag=%h exp v=1 tag=22", core_resp_valid[0], core_resp_bits_tag[31:0]);
    end
    step();
    core_resp_ready = 2'b01;
    mem_resp_valid = 2'b01;
    mem_resp_bits_tag[31:0] = 32'h23;
    step();
    mem_resp_valid = 2'b00;
    step();
    core_resp_ready = 2'b00;
    @(negedge clk);
    n_cmp++; if (credits_used !== 6'o00 || err_orphan_resp !== 2'b00) begin
      n_err++; $display("FAIL b2b_drain got credits=%o err=%b exp 00/00", credits_used, err_orphan_resp);
    end
    step();
  endtask

  task automatic test_orphan;
    mem_resp_valid = 2'b01;
    mem_resp_bits_tag[31:0] = 32'h7;
    step();
    mem_resp_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (err_orphan_resp !== 2'b01) begin n_err++; $display("FAIL orph_err got %b exp 01", err_orphan_resp); end
    n_cmp++; if (credits_used !== 6'o01) begin n_err++; $display("FAIL orph_used got %o exp 01", credits_used); end
    n_cmp++; if (core_resp_valid[0] !== 1'b1 || core_resp_bits_tag[31:0] !== 32'h7) begin
      n_err++; $display("FAIL orph_entry got v=%b tag=%h exp v=1 tag=7", core_resp_valid[0], core_resp_bits_tag[31:0]);
    end
    step();
    core_resp_ready = 2'b01;
    step();
    core_resp_ready = 2'b00;
    core_req_valid = 2'b01;
    step();
    core_req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (credits_used !== 6'o01) begin n_err++; $display("FAIL orph_inflight got %o exp 01", credits_used); end
    step();
    mem_resp_valid = 2'b01;
    core_resp_ready = 2'b01;
    step();
    mem_resp_valid = 2'b00;
    step();
    core_resp_ready = 2'b00;
    @(negedge clk);
    n_cmp++; if (err_orphan_resp !== 2'b01 || credits_used !== 6'o00) begin
      n_err++; $display("FAIL orph_sticky got err=%b credits=%o exp 01/00", err_orphan_resp, credits_used);
    end
    step();
  endtask

  task automatic test_lane_reset;
    core_req_valid = 2'b10;
    repeat (4) step();
    core_req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (credits_used !== 6'o40) begin n_err++; $display("FAIL lane_sat got %o exp 40", credits_used); end
    n_cmp++; if (core_req_ready !== 2'b01) begin n_err++; $display("FAIL lane_ready got %b exp 01", core_req_ready); end
    step();
    mem_resp_valid = 2'b10;
    mem_resp_bits_tag[63:32] = 32'h31;
    step();
    mem_resp_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (core_resp_valid !== 2'b10 || credits_used !== 6'o40) begin
      n_err++; $display("FAIL lane_buf got v=%b credits=%o exp 10/40", core_resp_valid, credits_used);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (credits_used !== 6'o00) begin n_err++; $display("FAIL areset_credits got %o exp 00", credits_used); end
    n_cmp++; if (core_resp_valid !== 2'b00) begin n_err++; $display("FAIL areset_valid got %b exp 00", core_resp_valid); end
    n_cmp++; if (err_orphan_resp !== 2'b00) begin n_err++; $display("FAIL areset_err got %b exp 00", err_orphan_resp); end
    n_cmp++; if (core_req_ready !== 2'b11 || mem_resp_ready !== 2'b11) begin
      n_err++; $display("FAIL areset_ready got req=%b resp=%b exp 11/11", core_req_ready, mem_resp_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    mem_resp_valid = 2'b10;
    step();
    mem_resp_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (err_orphan_resp !== 2'b10 || credits_used !== 6'o10) begin
      n_err++; $display("FAIL post_reset_orphan got err=%b credits=%o exp 10/10", err_orphan_resp, credits_used);
    end
  endtask

  initial begin
    test_reset();
    test_credit_cap();
    test_resp_latency();
    test_fifo_full();
    test_back_to_back();
    test_orphan();
    test_lane_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
